// File: rtl/ray_bbox_intersect_pipe.sv
// Four-stage pipelined ray/AABB slab test with valid/ready handshake and tag sideband.
// Define RAY_BBOX_SAT_EN to saturate the t narrowing in stage 2; default build wraps.
module ray_bbox_intersect_pipe #(
  parameter int DATA_W = 24,
  parameter int FRAC_W = 12,
  parameter int TAG_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TAG_W-1:0]      in_tag,
  input  logic [3*DATA_W-1:0]   ray_orig,
  input  logic [3*DATA_W-1:0]   inv_ray_dir,
  input  logic [3*DATA_W-1:0]   box_min,
  input  logic [3*DATA_W-1:0]   box_max,
  input  logic [2*DATA_W-1:0]   prev_range,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_hit,
  output logic [2*DATA_W-1:0]   out_range
);

  localparam int DW1 = DATA_W + 1;
  localparam int PW  = 2*DATA_W + 1;

`ifdef RAY_BBOX_SAT_EN
  function automatic logic signed [DATA_W-1:0] sat(input logic signed [PW-1:0] v);
    if (&v[PW-1:DATA_W-1] || ~|v[PW-1:DATA_W-1]) return v[DATA_W-1:0];
    else if (v[PW-1]) return {1'b1, {(DATA_W-1){1'b0}}};
    else return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction
`endif

  logic adv;
  logic v1_q, v2_q, v3_q, out_valid_q;
  logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q, out_tag_q;
  logic [2*DATA_W-1:0] prev1_q, prev2_q, out_range_q;
  logic out_hit_q;
  logic signed [DATA_W-1:0] prev_lo2, prev_hi2;
  logic [3*DATA_W-1:0] lo3, hi3;

  // A single global enable: the whole pipe moves or the whole pipe holds.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  assign prev_lo2 = prev2_q[DATA_W-1:0];
  assign prev_hi2 = prev2_q[2*DATA_W-1:DATA_W];

  for (genvar a = 0; a < 3; a++) begin : g_axis
    logic signed [DATA_W-1:0] orig, bmin, bmax, inv;
    logic signed [DW1-1:0]    dmin_d, dmax_d, dmin_q, dmax_q;
    logic signed [DATA_W-1:0] inv_q;
    logic signed [PW-1:0]     p0, p1, s0, s1;
    logic signed [DATA_W-1:0] t0_d, t1_d, t0_q, t1_q;
    logic                     neg_q;
    logic signed [DATA_W-1:0] n0, n1, lo_d, hi_d, lo_q, hi_q;

    assign orig = ray_orig[a*DATA_W +: DATA_W];
    assign bmin = box_min[a*DATA_W +: DATA_W];
    assign bmax = box_max[a*DATA_W +: DATA_W];
    assign inv  = inv_ray_dir[a*DATA_W +: DATA_W];

    assign dmin_d = DW1'(bmin) - DW1'(orig);
    assign dmax_d = DW1'(bmax) - DW1'(orig);

    assign p0 = PW'(dmin_q) * PW'(inv_q);
    assign p1 = PW'(dmax_q) * PW'(inv_q);
    assign s0 = p0 >>> FRAC_W;
    assign s1 = p1 >>> FRAC_W;

`ifdef RAY_BBOX_SAT_EN
    assign t0_d = sat(s0);
    assign t1_d = sat(s1);
`else
    assign t0_d = s0[DATA_W-1:0];
    assign t1_d = s1[DATA_W-1:0];
    logic unused_hi;
    assign unused_hi = ^{s0[PW-1:DATA_W], s1[PW-1:DATA_W]};
`endif

    // Negative direction enters the slab at the max plane.
    assign n0   = neg_q ? t1_q : t0_q;
    assign n1   = neg_q ? t0_q : t1_q;
    assign lo_d = (n0 > prev_lo2) ? n0 : prev_lo2;
    assign hi_d = (n1 < prev_hi2) ? n1 : prev_hi2;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dmin_q <= '0;
        dmax_q <= '0;
        inv_q  <= '0;
        t0_q   <= '0;
        t1_q   <= '0;
        neg_q  <= 1'b0;
        lo_q   <= '0;
        hi_q   <= '0;
      end else if (adv) begin
        dmin_q <= dmin_d;
        dmax_q <= dmax_d;
        inv_q  <= inv;
        t0_q   <= t0_d;
        t1_q   <= t1_d;
        neg_q  <= inv_q[DATA_W-1];
        lo_q   <= lo_d;
        hi_q   <= hi_d;
      end
    end

    assign lo3[a*DATA_W +: DATA_W] = lo_q;
    assign hi3[a*DATA_W +: DATA_W] = hi_q;
  end

  logic signed [DATA_W-1:0] lo_x, lo_y, lo_z, hi_x, hi_y, hi_z;
  logic signed [DATA_W-1:0] lo_xy, hi_xy, tlo_d, thi_d;
  logic                     hit_d;

  assign lo_x  = lo3[0*DATA_W +: DATA_W];
  assign lo_y  = lo3[1*DATA_W +: DATA_W];
  assign lo_z  = lo3[2*DATA_W +: DATA_W];
  assign hi_x  = hi3[0*DATA_W +: DATA_W];
  assign hi_y  = hi3[1*DATA_W +: DATA_W];
  assign hi_z  = hi3[2*DATA_W +: DATA_W];
  assign lo_xy = (lo_x > lo_y) ? lo_x : lo_y;
  assign tlo_d = (lo_xy > lo_z) ? lo_xy : lo_z;
  assign hi_xy = (hi_x < hi_y) ? hi_x : hi_y;
  assign thi_d = (hi_xy < hi_z) ? hi_xy : hi_z;
  // Strict compare: a zero-width interval counts as a miss.
  assign hit_d = tlo_d < thi_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      out_valid_q <= 1'b0;
      tag1_q      <= '0;
      tag2_q      <= '0;
      tag3_q      <= '0;
      out_tag_q   <= '0;
      prev1_q     <= '0;
      prev2_q     <= '0;
      out_hit_q   <= 1'b0;
      out_range_q <= '0;
    end else if (adv) begin
      v1_q        <= in_valid;
      v2_q        <= v1_q;
      v3_q        <= v2_q;
      out_valid_q <= v3_q;
      tag1_q      <= in_tag;
      tag2_q      <= tag1_q;
      tag3_q      <= tag2_q;
      out_tag_q   <= tag3_q;
      prev1_q     <= prev_range;
      prev2_q     <= prev1_q;
      out_hit_q   <= hit_d;
      out_range_q <= {thi_d, tlo_d};
    end
  end

  assign out_valid = out_valid_q;
  assign out_tag   = out_tag_q;
  assign out_hit   = out_hit_q;
  assign out_range = out_range_q;

endmodule

// File: tb/tb_ray_bbox_intersect_pipe.sv
// Randomized + directed bench for ray_bbox_intersect_pipe against an arithmetic slab-test model.
// Honours RAY_BBOX_SAT_EN the same way as the design build.
module tb_ray_bbox_intersect_pipe;
  localparam int ONE = 'h1000;

  typedef struct packed {
    logic [7:0]  tag;
    logic [47:0] prev;
    logic [71:0] bmax, bmin, inv, orig;
  } query_t;

  typedef struct packed {
    logic        hit;
    logic [23:0] hi, lo;
    logic [7:0]  tag;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_ready, out_hit;
  logic [7:0] out_tag;
  logic [47:0] out_range;
  query_t cur;

  always #5 clk = ~clk;

  ray_bbox_intersect_pipe #(.DATA_W(24), .FRAC_W(12), .TAG_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(cur.tag),
    .ray_orig(cur.orig), .inv_ray_dir(cur.inv), .box_min(cur.bmin), .box_max(cur.bmax),
    .prev_range(cur.prev),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_hit(out_hit), .out_range(out_range)
  );

  int checks = 0, errors = 0, pops = 0;
  res_t sb[$];
  logic was_stalled = 1'b0, acc = 1'b0;
  logic [56:0] held;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic longint sx(input logic [23:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint nar(input longint x);
`ifdef RAY_BBOX_SAT_EN
    if (x > 8388607) return 8388607;
    if (x < -8388608) return -8388608;
    return x;
`else
    logic [63:0] b;
    b = x;
    return sx(b[23:0]);
`endif
  endfunction

  // Interval clipping: start from prev and narrow it with each axis slab.
  function automatic res_t model(input query_t q);
    res_t r;
    longint lo, hi, inv, t0, t1, tmp;
    lo = sx(q.prev[23:0]);
    hi = sx(q.prev[47:24]);
    for (int a = 0; a < 3; a++) begin
      inv = sx(q.inv[a*24 +: 24]);
      t0 = nar(((sx(q.bmin[a*24 +: 24]) - sx(q.orig[a*24 +: 24])) * inv) >>> 12);
      t1 = nar(((sx(q.bmax[a*24 +: 24]) - sx(q.orig[a*24 +: 24])) * inv) >>> 12);
      if (inv < 0) begin tmp = t0; t0 = t1; t1 = tmp; end
      if (t0 > lo) lo = t0;
      if (t1 < hi) hi = t1;
    end
    r.hit = lo < hi;
    r.lo  = lo[23:0];
    r.hi  = hi[23:0];
    r.tag = q.tag;
    return r;
  endfunction

  function automatic logic [71:0] v3(input int x, input int y, input int z);
    return {z[23:0], y[23:0], x[23:0]};
  endfunction

  function automatic logic [47:0] p2(input int lo, input int hi);
    return {hi[23:0], lo[23:0]};
  endfunction

  function automatic logic [71:0] r72();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[71:0];
  endfunction

  function automatic int rcoord();
    return int'($urandom_range(0, 'h40000)) - 'h20000;
  endfunction

  function automatic query_t rnd_q(input logic [7:0] tag);
    query_t q;
    int a0, a1, iv, lo, hi;
    logic [63:0] t;
    for (int a = 0; a < 3; a++) begin
      a0 = rcoord(); a1 = rcoord();
      if (a0 > a1 && $urandom_range(0, 3) != 0) begin iv = a0; a0 = a1; a1 = iv; end
      case ($urandom_range(0, 7))
        0: iv = 0;
        1: iv = 'h7FFFFF;
        2: iv = -'h800000;
        default: iv = int'($urandom_range(0, 'h8000)) - 'h4000;
      endcase
      lo = rcoord() / 4;
      q.bmin[a*24 +: 24] = a0[23:0];
      q.bmax[a*24 +: 24] = a1[23:0];
      q.inv[a*24 +: 24]  = iv[23:0];
      q.orig[a*24 +: 24] = lo[23:0];
    end
    lo = int'($urandom_range(0, 'h2000));
    hi = lo + int'($urandom_range(0, 'h3E8000));
    q.prev = p2(lo, hi);
    if ($urandom_range(0, 7) == 0) begin
      q.orig = r72(); q.inv = r72(); q.bmin = r72(); q.bmax = r72();
      t = {$urandom(), $urandom()};
      q.prev = t[47:0];
    end
    q.tag = tag;
    return q;
  endfunction

  task automatic step(input logic iv, input query_t q, input logic ordy);
    res_t e;
    @(negedge clk);
    in_valid = iv; cur = q; out_ready = ordy;
    #1;
    chk("in_ready", in_ready, !out_valid || out_ready);
    if (was_stalled) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", {out_hit, out_tag, out_range}, held);
    end
    was_stalled = out_valid && !out_ready;
    held = {out_hit, out_tag, out_range};
    acc = iv && in_ready;
    if (acc) sb.push_back(model(q));
    if (out_valid && out_ready) begin
      pops++;
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("tag", out_tag, e.tag);
        chk("hit", out_hit, e.hit);
        chk("range", out_range, {e.hi, e.lo});
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) step(1'b0, cur, 1'b1);
    chk("drained", sb.size(), 0);
  endtask

  // Single query on an empty pipe: checks latency and fixed expected values.
  task automatic run_one(input string nm, input query_t q, input logic eh,
                         input logic [23:0] elo, input logic [23:0] ehi);
    step(1'b1, q, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (k < 4) chk({nm, "_early"}, out_valid, 0);
    end
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_hit"}, out_hit, eh);
    chk({nm, "_lo"}, out_range[23:0], elo);
    chk({nm, "_hi"}, out_range[47:24], ehi);
    chk({nm, "_tag"}, out_tag, q.tag);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    query_t q;
    query_t qs[6];
    int idx, p0, low;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cur = '0;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_hit", out_hit, 0);
    chk("rst_range", out_range, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk); rst = 1'b0;

    q.orig = v3(0, 0, 0); q.inv = v3(ONE, ONE, ONE);
    q.bmin = v3(ONE, ONE, ONE); q.bmax = v3(2*ONE, 2*ONE, 2*ONE);
    q.prev = p2(0, 100*ONE); q.tag = 8'h5A;
    run_one("t1", q, 1'b1, 24'h001000, 24'h002000);
    drain();

    q.inv = v3(-ONE, ONE, ONE); q.bmin = v3(-2*ONE, ONE, ONE); q.bmax = v3(-ONE, 2*ONE, 2*ONE);
    q.tag = 8'h21;
    run_one("t2", q, 1'b1, 24'h001000, 24'h002000);
    drain();

    q.inv = v3(ONE, ONE, ONE); q.bmin = v3(ONE, 3*ONE, ONE); q.bmax = v3(2*ONE, 4*ONE, 2*ONE);
    q.tag = 8'h33;
    run_one("t3a", q, 1'b0, 24'h003000, 24'h002000);
    drain();

    q.bmin = v3(ONE, ONE, ONE); q.bmax = v3(ONE, 2*ONE, 2*ONE); q.tag = 8'h34;
    run_one("t3b", q, 1'b0, 24'h001000, 24'h001000);
    drain();

    q.orig = v3(0, 0, 0); q.inv = v3('h100000, 'h100000, 'h100000);
    q.bmin = v3(0, 0, 0); q.bmax = v3('h7FF000, 'h7FFFFF, 'h7FFFFF);
    q.prev = p2(0, 'h7FFFFF); q.tag = 8'h44;
`ifdef RAY_BBOX_SAT_EN
    run_one("t4", q, 1'b1, 24'h000000, 24'h7FFFFF);
`else
    run_one("t4", q, 1'b0, 24'h000000, 24'hF00000);
`endif
    drain();

    for (int i = 0; i < 6; i++) qs[i] = rnd_q(8'(8'h60 + i));
    idx = 0; p0 = pops; low = 0;
    for (int c = 0; c < 20; c++) begin
      step(idx < 6, qs[idx < 6 ? idx : 0], !(c >= 5 && c < 8));
      if (!in_ready) low++;
      if (acc) idx++;
    end
    chk("t5_sent", idx, 6);
    chk("t5_pops", pops - p0, 6);
    chk("t5_in_ready_low", low, 3);
    drain();

    for (int c = 0; c < 300; c++)
      step($urandom_range(0, 3) != 0, rnd_q(8'($urandom)), $urandom_range(0, 3) != 0);
    drain();

    step(1'b1, rnd_q(8'h71), 1'b0);
    step(1'b1, rnd_q(8'h72), 1'b0);
    step(1'b1, rnd_q(8'h73), 1'b0);
    step(1'b0, cur, 1'b0);
    step(1'b0, cur, 1'b0);
    chk("t6_pre_valid", out_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_hit", out_hit, 0);
    chk("t6_range", out_range, 0);
    chk("t6_tag", out_tag, 0);
    chk("t6_in_ready", in_ready, 1);
    sb.delete();
    was_stalled = 1'b0;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step(1'b0, cur, 1'b1);
      chk("t6_no_stale", out_valid, 0);
    end
    q.orig = v3(0, 0, 0); q.inv = v3(ONE, ONE, ONE);
    q.bmin = v3(ONE, ONE, ONE); q.bmax = v3(2*ONE, 2*ONE, 2*ONE);
    q.prev = p2(0, 100*ONE); q.tag = 8'h99;
    run_one("t6_new", q, 1'b1, 24'h001000, 24'h002000);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
